// File: rtl/vuelto_pkg.sv
// Shared types and default timing for the coin-change dispenser.
package vuelto_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_JAM
    } state_t;

    localparam int T_PULSE_DEF   = 4;
    localparam int T_GAP_DEF     = 2;
    localparam int T_WAIT_DEF    = 16;
    localparam int MAX_RETRY_DEF = 2;

endpackage

// File: rtl/vuelto_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module vuelto_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/vuelto_dispenser.sv
// Hopper payout controller: pulses the motor once per coin, retries, jams.
module vuelto_dispenser
    import vuelto_pkg::*;
#(
    parameter int T_PULSE   = T_PULSE_DEF,
    parameter int T_GAP     = T_GAP_DEF,
    parameter int T_WAIT    = T_WAIT_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] vuelto,
    input  logic       vuelto_valid,
    input  logic       moneda_sensor,
    input  logic       tolva_vacia,
    input  logic       clear_jam,
    output logic       motor,
    output logic       busy,
    output logic       done,
    output logic       jam,
    output logic [2:0] pendiente
);

    localparam int TW = $clog2(T_PULSE + T_GAP + T_WAIT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t          state_q, state_d, pulse_or_jam;
    logic [2:0]      pend_q, pend_d;
    logic [RW-1:0]   retry_q, retry_d, retry_inc;
    logic            sens_q, sens_edge;
    logic            t_load, t_exp;
    logic [TW-1:0]   t_val;

    assign sens_edge    = moneda_sensor & ~sens_q;
    assign retry_inc    = retry_q + RW'(1);
    assign pulse_or_jam = tolva_vacia ? S_JAM : S_PULSE;
    assign pendiente    = pend_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            retry_q <= '0;
            sens_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            retry_q <= retry_d;
            sens_q  <= moneda_sensor;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        retry_d = retry_q;
        motor   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        jam     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (vuelto_valid) begin
                    if (vuelto != 3'd0) begin
                        pend_d  = vuelto;
                        retry_d = '0;
                        state_d = pulse_or_jam;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PULSE: begin
                motor = 1'b1;
                if (sens_edge && pend_q != 3'd0) begin
                    pend_d  = pend_q - 3'd1;
                    retry_d = '0;
                    state_d = (pend_q == 3'd1) ? S_DONE : S_GAP;
                end else if (t_exp) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sens_edge && pend_q != 3'd0) begin
                    pend_d  = pend_q - 3'd1;
                    retry_d = '0;
                    state_d = (pend_q == 3'd1) ? S_DONE : S_GAP;
                end else if (t_exp) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc < RW'(MAX_RETRY)) ? pulse_or_jam
                                                           : S_JAM;
                end
            end
            S_GAP: begin
                if (t_exp) begin
                    state_d = pulse_or_jam;
                end
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_JAM: begin
                jam = 1'b1;
                if (clear_jam) begin
                    pend_d  = '0;
                    retry_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The shared timer is reloaded on every entry into a timed state.
    always_comb begin
        t_load = (state_d != state_q);
        t_val  = '0;
        case (state_d)
            S_PULSE: t_val = TW'(T_PULSE - 1);
            S_WAIT:  t_val = TW'(T_WAIT - 1);
            S_GAP:   t_val = TW'(T_GAP - 1);
            default: t_val = '0;
        endcase
    end

    vuelto_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .expired  (t_exp)
    );

endmodule

// File: tb/tb_vuelto_dispenser.sv
// Randomized bench for vuelto_dispenser against a per-payout timing model.
module tb_vuelto_dispenser;

    localparam int TP = 4;
    localparam int TG = 2;
    localparam int TW = 16;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] vuelto;
    logic       vuelto_valid;
    logic       moneda_sensor;
    logic       tolva_vacia;
    logic       clear_jam;
    logic       motor, busy, done, jam;
    logic [2:0] pendiente;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vuelto_dispenser #(
        .T_PULSE   (TP),
        .T_GAP     (TG),
        .T_WAIT    (TW),
        .MAX_RETRY (MR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vuelto        (vuelto),
        .vuelto_valid  (vuelto_valid),
        .moneda_sensor (moneda_sensor),
        .tolva_vacia   (tolva_vacia),
        .clear_jam     (clear_jam),
        .motor         (motor),
        .busy          (busy),
        .done          (done),
        .jam           (jam),
        .pendiente     (pendiente)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        vuelto = '0; vuelto_valid = 0; moneda_sensor = 0;
        tolva_vacia = 0; clear_jam = 0;
        step(); step();
        n_total++;
        if ({motor, busy, done, jam, pendiente} !== 7'b0)
            $display("FAIL reset_outputs got=%b want=0000000",
                     {motor, busy, done, jam, pendiente});
        else n_pass++;
        reset = 1'b1;
        step();
    endtask

    // Random coin counts; each coin is sensed at a random point of its wait.
    task automatic test_payout();
        for (int it = 0; it < 6; it++) begin
            int n, rem, run, tot_m, dones, delay, post, cyc;
            logic prev_m;
            n = $urandom_range(1, 7);
            rem = n; run = 0; tot_m = 0; dones = 0;
            delay = -1; post = 0; prev_m = 1'b0;
            vuelto = 3'(n); vuelto_valid = 1; step(); vuelto_valid = 0;
            n_total++;
            if (pendiente !== 3'(n))
                $display("FAIL payout_load got=%0d want=%0d", pendiente, n);
            else n_pass++;
            for (cyc = 0; cyc < 400; cyc++) begin
                if (motor) begin run++; tot_m++; end
                if (done) dones++;
                if (dones > 0) post++;
                if (moneda_sensor) begin
                    moneda_sensor = 0;
                    rem--;
                    n_total++;
                    if (pendiente !== 3'(rem))
                        $display("FAIL payout_pend got=%0d want=%0d",
                                 pendiente, rem);
                    else n_pass++;
                end
                if (prev_m && !motor) begin
                    n_total++;
                    if (run != TP)
                        $display("FAIL pulse_len got=%0d want=%0d", run, TP);
                    else n_pass++;
                    run = 0;
                    delay = $urandom_range(0, TW - 1);
                end
                if (delay == 0) begin
                    moneda_sensor = 1; delay = -1;
                end else if (delay > 0) delay--;
                if (post == 4) break;
                prev_m = motor;
                step();
            end
            n_total++;
            if (cyc >= 400) $display("FAIL payout_timeout got=%0d want<400", cyc);
            else n_pass++;
            n_total++;
            if (dones != 1) $display("FAIL done_count got=%0d want=1", dones);
            else n_pass++;
            n_total++;
            if (tot_m != n * TP)
                $display("FAIL motor_total got=%0d want=%0d", tot_m, n * TP);
            else n_pass++;
            n_total++;
            if ({busy, pendiente} !== 4'b0)
                $display("FAIL payout_end got=%b want=0000", {busy, pendiente});
            else n_pass++;
        end
    endtask

    task automatic test_zero();
        vuelto = 3'd0; vuelto_valid = 1; step(); vuelto_valid = 0;
        n_total++;
        if ({done, motor, busy} !== 3'b100)
            $display("FAIL zero_done got=%b want=100", {done, motor, busy});
        else n_pass++;
        step();
        n_total++;
        if ({done, motor, busy} !== 3'b000)
            $display("FAIL zero_after got=%b want=000", {done, motor, busy});
        else n_pass++;
    endtask

    // No coins ever arrive: MR attempts of pulse plus full wait, then jam.
    task automatic test_jam();
        for (int it = 0; it < 3; it++) begin
            int n, jam_at, pulses, mcyc;
            logic prev_m;
            n = $urandom_range(1, 7);
            jam_at = -1; pulses = 0; mcyc = 0; prev_m = 1'b0;
            vuelto = 3'(n); vuelto_valid = 1; step(); vuelto_valid = 0;
            for (int c = 1; c <= 80; c++) begin
                clear_jam = (c == 2);
                if (motor) mcyc++;
                if (motor && !prev_m) pulses++;
                if (jam) begin jam_at = c; break; end
                prev_m = motor;
                step();
            end
            clear_jam = 0;
            n_total++;
            if (jam_at != 1 + MR * (TP + TW))
                $display("FAIL jam_time got=%0d want=%0d", jam_at,
                         1 + MR * (TP + TW));
            else n_pass++;
            n_total++;
            if (pulses != MR || mcyc != MR * TP)
                $display("FAIL jam_pulses got=%0d/%0d want=%0d/%0d",
                         pulses, mcyc, MR, MR * TP);
            else n_pass++;
            n_total++;
            if ({motor, busy, pendiente} !== {2'b01, 3'(n)})
                $display("FAIL jam_state got=%b want=%b",
                         {motor, busy, pendiente}, {2'b01, 3'(n)});
            else n_pass++;
            moneda_sensor = 1; step(); moneda_sensor = 0; step();
            n_total++;
            if ({jam, pendiente} !== {1'b1, 3'(n)})
                $display("FAIL jam_sensor got=%b want=%b",
                         {jam, pendiente}, {1'b1, 3'(n)});
            else n_pass++;
            clear_jam = 1; step(); clear_jam = 0;
            n_total++;
            if ({jam, busy, pendiente} !== 5'b0)
                $display("FAIL jam_clear got=%b want=00000",
                         {jam, busy, pendiente});
            else n_pass++;
        end
    endtask

    task automatic test_tolva();
        tolva_vacia = 1;
        vuelto = 3'd2; vuelto_valid = 1; step(); vuelto_valid = 0;
        n_total++;
        if ({jam, motor, busy, pendiente} !== 6'b101010)
            $display("FAIL tolva_jam got=%b want=101010",
                     {jam, motor, busy, pendiente});
        else n_pass++;
        step(); step();
        n_total++;
        if (motor !== 1'b0) $display("FAIL tolva_motor got=%b want=0", motor);
        else n_pass++;
        tolva_vacia = 0; clear_jam = 1; step(); clear_jam = 0;
        n_total++;
        if ({jam, busy} !== 2'b00)
            $display("FAIL tolva_clear got=%b want=00", {jam, busy});
        else n_pass++;
    endtask

    task automatic wait_fall(input string tag);
        int k;
        for (k = 0; k < 20; k++) begin
            step();
            if (!motor) break;
        end
        n_total++;
        if (k >= 20) $display("FAIL %s got=timeout want=motor_fall", tag);
        else n_pass++;
    endtask

    task automatic test_midpayout();
        reset = 0; moneda_sensor = 1; step();
        reset = 1; step();
        vuelto = 3'd3; vuelto_valid = 1; step();
        vuelto = 3'd7;
        step(); vuelto_valid = 0; step();
        n_total++;
        if ({motor, pendiente} !== 4'b1011)
            $display("FAIL held_sensor got=%b want=1011", {motor, pendiente});
        else n_pass++;
        moneda_sensor = 0;
        wait_fall("fall1");
        moneda_sensor = 1; step(); moneda_sensor = 0;
        n_total++;
        if ({motor, pendiente} !== 4'b0010)
            $display("FAIL wait_coin got=%b want=0010", {motor, pendiente});
        else n_pass++;
        step(); moneda_sensor = 1; step(); moneda_sensor = 0;
        n_total++;
        if ({motor, pendiente} !== 4'b1010)
            $display("FAIL gap_ignore got=%b want=1010", {motor, pendiente});
        else n_pass++;
        wait_fall("fall2");
        step(); step();
        reset = 0; #1;
        n_total++;
        if ({motor, busy, done, jam, pendiente} !== 7'b0)
            $display("FAIL async_reset got=%b want=0000000",
                     {motor, busy, done, jam, pendiente});
        else n_pass++;
        step();
        reset = 1; step();
        n_total++;
        if ({done, busy} !== 2'b00)
            $display("FAIL reset_nodone got=%b want=00", {done, busy});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_payout();
        test_jam();
        test_tolva();
        test_midpayout();
        test_payout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vuelto_dispenser.md
VUELTO_DISPENSER -- requirements
Module: vuelto_dispenser

Interface
REQ-001 Parameter T_PULSE, default 4, is the number of cycles motor stays high per dispense attempt.
REQ-002 Parameter T_GAP, default 2, is the number of motor-off cycles between successive coins.
REQ-003 Parameter T_WAIT, default 16, is the number of cycles to wait for the coin sensor after a pulse ends.
REQ-004 Parameter MAX_RETRY, default 2, is the number of failed attempts per coin before jam.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1 bit: system clock; all logic samples on the rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-008 Port vuelto, input, 3 bits: number of change coins to pay, 0-7.
REQ-009 Port vuelto_valid, input, 1 bit: one-cycle strobe qualifying vuelto.
REQ-010 Port moneda_sensor, input, 1 bit: coin-passed sensor, already synchronous, level high while a coin passes.
REQ-011 Port tolva_vacia, input, 1 bit: hopper-empty flag.
REQ-012 Port clear_jam, input, 1 bit: operator acknowledge that exits the jam state.
REQ-013 Port motor, output, 1 bit: hopper motor drive.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-015 Port done, output, 1 bit: one-cycle pulse when the payout is complete.
REQ-016 Port jam, output, 1 bit: high while in JAM.
REQ-017 Port pendiente, output, 3 bits: coins still to dispense.

Function
REQ-018 The FSM states SHALL be IDLE, PULSE, WAIT, GAP, DONE and JAM.
REQ-019 In IDLE, vuelto_valid with vuelto!=0 SHALL load pendiente=vuelto, clear the retry count and enter PULSE on the next edge.
REQ-020 In IDLE, vuelto_valid with vuelto==0 SHALL enter DONE without driving motor.
REQ-021 vuelto_valid SHALL be ignored in every state other than IDLE.
REQ-022 On entry to PULSE, if tolva_vacia=1 the FSM SHALL go to JAM instead, with motor held at 0.
REQ-023 In PULSE, motor SHALL be 1 for exactly T_PULSE cycles, after which the FSM enters WAIT.
REQ-024 Rising edges of moneda_sensor SHALL be counted only in PULSE and WAIT, at most one per attempt.
REQ-025 Each counted edge SHALL decrement pendiente and clear the retry count.
REQ-026 After a counted edge, if pendiente reaches 0 the FSM SHALL enter DONE (from PULSE, motor drops immediately); otherwise it SHALL enter GAP.
REQ-027 If WAIT lasts T_WAIT cycles with no edge, the retry count SHALL increment.
REQ-028 After that increment, if retry count < MAX_RETRY the FSM SHALL return to PULSE; otherwise it SHALL enter JAM.
REQ-029 GAP SHALL hold motor at 0 for T_GAP cycles, then enter PULSE.
REQ-030 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 In JAM: jam=1, motor=0, and pendiente holds the undelivered count.
REQ-032 clear_jam in JAM SHALL clear pendiente and the retry count and go to IDLE.
REQ-033 clear_jam outside JAM SHALL be ignored.
REQ-034 Edges of moneda_sensor in IDLE, GAP, DONE or JAM SHALL be ignored.
REQ-035 pendiente arithmetic SHALL be 3-bit unsigned and never underflow below 0.

Reset
REQ-036 reset low SHALL force IDLE, motor=0, busy=0, done=0, jam=0, pendiente=0, retry=0, timer=0 and the sensor edge register=0.
REQ-037 Assertion of reset mid-payout SHALL abandon the payout immediately, with no done pulse.
REQ-038 After reset release, a sensor already high SHALL NOT count as an edge.

Structure
REQ-039 Package vuelto_pkg SHALL hold the state enum and the default values of T_PULSE, T_GAP, T_WAIT and MAX_RETRY.
REQ-040 A single sub-module, vuelto_timer, SHALL provide a loadable down-counter with an expiry flag, shared by PULSE, GAP and WAIT.

Verification (default parameters)
REQ-041 vuelto=3 strobe; one sensor pulse per attempt during WAIT -> three 4-cycle motor pulses; pendiente 3,2,1,0; done pulses once; busy low afterward.
REQ-042 vuelto=0 strobe -> done pulse one cycle later; motor never high; busy stays low.
REQ-043 vuelto=2; no sensor activity -> two pulses, each followed by a 16-cycle wait; then jam=1 with pendiente=2; clear_jam -> IDLE with pendiente=0.
REQ-044 vuelto=2 with tolva_vacia=1 -> JAM on the cycle after the strobe; motor never asserted.
REQ-045 Mid-payout: a second vuelto_valid is ignored; a sensor pulse in GAP is not counted; reset asserted in WAIT clears all outputs immediately.
